icache_ctrl: RTL and testbench

Direct-mapped instruction cache controller between the fetch stage and the instruction memory. It holds `LINES` cached 16-word blocks and answers fetch requests on a hit in the same cycle. On a miss it stalls fetch, presents the block address to the memory's block port, and waits a modelled `MEM_LATENCY`. It then captures the whole block into the line and releases the stall.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_ctrl_if.sv | 29 ++
 rtl/icache_line_store.sv | 59 +++++
 rtl/icache_ctrl.sv | 140 ++++++++++++++
 tb/tb_icache_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and geometry helpers for the direct-mapped
// instruction cache (state encoding, block/offset constants, index/tag width
// derivation and the MSB-first block-word position helper).
package icache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   // Words per block and the matching offset width (pc[3:0]).
   localparam int BLK_WORDS = 16;
   localparam int OFF_W     = 4;

   // Index width for a power-of-two line count.
   function automatic int idx_width(input int lines);
      return $clog2(lines);
   endfunction

   // Tag keeps everything above offset and index.
   function automatic int tag_width(input int word_size, input int lines);
      return word_size - OFF_W - idx_width(lines);
   endfunction

   // LSB position of word i inside a flat block; word 0 lives in the MSBs.
   function automatic int word_lsb(input int i, input int word_size);
      return word_size * (BLK_WORDS - 1 - i);
   endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: fetch-side and memory-block-side signals of the cache.
//
// Handshake: fetch_req is the request qualifier for pc. stall is the back
// pressure: while stall is high the requester keeps fetch_req and pc
// unchanged. A word is delivered in any cycle where fetch_req and
// inst_valid are both high; inst is only meaningful then (driven 0 otherwise).
interface icache_ctrl_if #(
   parameter int WORD_SIZE  = 32,
   parameter int BLOCK_SIZE = 16
);
   logic                            fetch_req;
   logic [WORD_SIZE-1:0]            pc;
   logic                            flush;
   logic [WORD_SIZE-1:0]            inst;
   logic                            inst_valid;
   logic                            stall;
   logic [WORD_SIZE-1:0]            mem_ptr;
   logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block;

   modport master (
      output fetch_req, pc, flush, mem_block,
      input  inst, inst_valid, stall, mem_ptr
   );

   modport slave (
      input  fetch_req, pc, flush, mem_block,
      output inst, inst_valid, stall, mem_ptr
   );
endinterface

// File: rtl/icache_line_store.sv
// icache_line_store: valid bits, tags and data words for every cache line.
// Asynchronous read of one word by index/offset, whole-line write of a
// block. Only the valid bits are reset; inv_all clears them all at the edge.
module icache_line_store
   import icache_pkg::*;
#(
   parameter int  WORD_SIZE = 32,
   parameter int  LINES     = 8,
   localparam int IDX_W     = idx_width(LINES),
   localparam int TAG_W     = tag_width(WORD_SIZE, LINES)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [IDX_W-1:0]              rd_idx,
   input  logic [OFF_W-1:0]              rd_off,
   output logic                          rd_valid,
   output logic [TAG_W-1:0]              rd_tag,
   output logic [WORD_SIZE-1:0]          rd_word,
   input  logic                          wr_en,
   input  logic [IDX_W-1:0]              wr_idx,
   input  logic [TAG_W-1:0]              wr_tag,
   input  logic [WORD_SIZE*BLK_WORDS-1:0] wr_block,
   input  logic                          inv_all
);

   logic [LINES-1:0]     valid;
   logic [TAG_W-1:0]     tag_mem  [LINES];
   logic [WORD_SIZE-1:0] data_mem [LINES][BLK_WORDS];
   logic [WORD_SIZE-1:0] blk_words [BLK_WORDS];

   // Split the flat block into words, word 0 taken from the MSBs.
   for (genvar g = 0; g < BLK_WORDS; g++) begin : g_unpack
      assign blk_words[g] = wr_block[word_lsb(g, WORD_SIZE) +: WORD_SIZE];
   end

   // Valid bits: reset and invalidate-all win over a line fill.
   always_ff @(posedge clk) begin
      if (reset || inv_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data arrays: written as a whole line, never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx] <= wr_tag;
         for (int i = 0; i < BLK_WORDS; i++) begin
            data_mem[wr_idx][i] <= blk_words[i];
         end
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_word  = data_mem[rd_idx][rd_off];

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller. Hits answer in
// the same cycle; a miss stalls fetch for MEM_LATENCY cycles of FILL, then
// captures the whole block from mem_block and releases the stall.
// Optional feature macro: ICACHE_STATS_EN adds hit_count / miss_count.
module icache_ctrl
   import icache_pkg::*;
#(
   parameter int WORD_SIZE   = 32,
   parameter int BLOCK_SIZE  = 16,
   parameter int LINES       = 8,
   parameter int MEM_LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   icache_ctrl_if.slave bus,
`ifdef ICACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   output state_t      dbg_state
);

   localparam int IDX_W = idx_width(LINES);
   localparam int TAG_W = tag_width(WORD_SIZE, LINES);
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [OFF_W-1:0]     offset;
   logic [IDX_W-1:0]     index;
   logic [TAG_W-1:0]     tag;
   logic                 rd_valid;
   logic [TAG_W-1:0]     rd_tag;
   logic [WORD_SIZE-1:0] rd_word;
   logic                 hit;
   logic                 fill_we;
   logic                 inst_valid;
   logic                 stall;
   logic [WORD_SIZE-1:0] inst;
   logic [WORD_SIZE*BLOCK_SIZE-1:0] fill_block;

   assign offset     = bus.pc[OFF_W-1:0];
   assign index      = bus.pc[OFF_W +: IDX_W];
   assign tag        = bus.pc[WORD_SIZE-1 -: TAG_W];
   assign fill_block = bus.mem_block;
   assign hit        = bus.fetch_req & rd_valid & (rd_tag == tag);

   icache_line_store #(
      .WORD_SIZE (WORD_SIZE),
      .LINES     (LINES)
   ) u_store (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (index),
      .rd_off   (offset),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_word  (rd_word),
      .wr_en    (fill_we & ~reset),
      .wr_idx   (index),
      .wr_tag   (tag),
      .wr_block (fill_block),
      .inv_all  (bus.flush)
   );

   // State and latency counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next state, fill strobe and fetch-side outputs. Outputs reflect the
   // pre-flush lookup; flush only overrides the next state and the fill.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      fill_we    = 1'b0;
      inst_valid = 1'b0;
      stall      = 1'b0;
      inst       = '0;
      case (state)
         IDLE: begin
            if (bus.fetch_req) begin
               if (hit) begin
                  inst_valid = 1'b1;
                  inst       = rd_word;
               end else begin
                  stall   = 1'b1;
                  cnt_n   = '0;
                  state_n = FILL;
               end
            end
         end
         FILL: begin
            stall = 1'b1;
            if (cnt == CNT_LAST) begin
               fill_we = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (bus.flush) begin
         fill_we = 1'b0;
         state_n = IDLE;
      end
   end

   assign bus.inst       = inst;
   assign bus.inst_valid = inst_valid;
   assign bus.stall      = stall;
   assign bus.mem_ptr    = {bus.pc[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
   assign dbg_state      = state;

`ifdef ICACHE_STATS_EN
   // Hit and miss event counters; survive flush, wrap modulo 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (state == IDLE && hit) begin
            hit_count <= hit_count + 32'd1;
         end
         if (state == IDLE && state_n == FILL) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: self-checking bench for icache_ctrl (ICACHE_STATS_EN aware).
module tb_icache_ctrl;
   import icache_pkg::*;

   localparam int W     = 32;
   localparam int LAT   = 4;
   localparam int LINES = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   icache_ctrl_if #(.WORD_SIZE(W), .BLOCK_SIZE(16)) bus ();
   icache_ctrl_if #(.WORD_SIZE(W), .BLOCK_SIZE(16)) bus1 ();
   state_t dbg_state, dbg_state1;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count, hit_count1, miss_count1;
`endif

   icache_ctrl #(.WORD_SIZE(W), .BLOCK_SIZE(16), .LINES(LINES), .MEM_LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
`ifdef ICACHE_STATS_EN
      .hit_count  (hit_count),
      .miss_count (miss_count),
`endif
      .dbg_state  (dbg_state)
   );

   icache_ctrl #(.WORD_SIZE(W), .BLOCK_SIZE(16), .LINES(LINES), .MEM_LATENCY(1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus1),
`ifdef ICACHE_STATS_EN
      .hit_count  (hit_count1),
      .miss_count (miss_count1),
`endif
      .dbg_state  (dbg_state1)
   );

   // ---------------- memory model ----------------
   function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   function automatic logic [W*16-1:0] build_block(input logic [W-1:0] ptr);
      logic [W*16-1:0] b;
      b = '0;
      for (int i = 0; i < 16; i++) begin
         b[W*(16-i)-1 -: W] = mem_word(ptr + W'(i));
      end
      return b;
   endfunction

   assign bus.mem_block  = build_block(bus.mem_ptr);
   assign bus1.mem_block = build_block(bus1.mem_ptr);

   // ---------------- scoreboard / checking ----------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];
   int exp_hits   = 0;
   int exp_misses = 0;

   // Reference cache contents: valid and block address per line.
   logic          m_valid [LINES];
   logic [W-5:0]  m_blk   [LINES];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int model_stalls(input logic [W-1:0] a);
      int idx;
      idx = int'(a[6:4]);
      return (m_valid[idx] && m_blk[idx] == a[W-1:4]) ? 0 : LAT + 1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
   endtask

   // Output monitor: every delivered word is checked against the queue head.
   always @(negedge clk) begin
      if (!reset && bus.fetch_req && bus.inst_valid) begin
         if (exp_q.size() == 0) check("unexp_hit", 32'(bus.inst_valid), 32'd0);
         else check("inst", bus.inst, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_fetch(input logic [W-1:0] a, input int exp_stalls, input string tag);
      int n;
      n = 0;
      bus.pc        = a;
      bus.fetch_req = 1'b1;
      exp_q.push_back(mem_word(a));
      @(negedge clk);
      if (exp_stalls > 0) check({tag, "_ptr"}, bus.mem_ptr, {a[W-1:4], 4'h0});
      while (bus.stall && n < 50) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
      check({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
      if (exp_stalls > 0) exp_misses++;
      exp_hits++;
      m_valid[int'(a[6:4])] = 1'b1;
      m_blk[int'(a[6:4])]   = a[W-1:4];
      @(posedge clk); #1;
      bus.fetch_req = 1'b0;
   endtask

   task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
      check({tag, "_hits"}, hit_count, 32'(exp_hits));
      check({tag, "_misses"}, miss_count, 32'(exp_misses));
`else
      check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
`endif
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      logic [W-1:0] a;
      reset          = 1'b1;
      bus.fetch_req  = 1'b0;
      bus.pc         = '0;
      bus.flush      = 1'b0;
      bus1.fetch_req = 1'b0;
      bus1.pc        = '0;
      bus1.flush     = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check_stats("rst");
      @(posedge clk); #1;

      // First miss, then a full sweep of the block with back-to-back hits.
      do_fetch(32'h23, LAT + 1, "miss23");
      for (int i = 0; i < 16; i++) do_fetch(32'h20 + 32'(i), 0, "sweep");
      check_stats("sweep");

      // Conflict on index 2: 0xA3 evicts 0x23, then 0x23 misses again.
      do_fetch(32'hA3, LAT + 1, "conf_a3");
      do_fetch(32'h23, LAT + 1, "conf_23");

      // Flush on the 2nd FILL cycle: fill abandoned, held pc restarts.
      bus.pc        = 32'h140;
      bus.fetch_req = 1'b1;
      @(negedge clk);
      check("fl_miss", 32'(bus.stall), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.flush = 1'b1;
      @(negedge clk);
      check("fl_state", 32'(dbg_state), 32'(FILL));
      @(posedge clk); #1;
      bus.flush = 1'b0;
      model_clear();
      exp_misses++;
      do_fetch(32'h140, LAT + 1, "fl_refill");
      do_fetch(32'h23, LAT + 1, "fl_23");
      check_stats("flush");

      // Random fetches against the reference model.
      repeat (24) begin
         a = W'($urandom_range(0, 511));
         do_fetch(a, model_stalls(a), "rnd");
      end
      check_stats("rnd");

      // Reset in the middle of a fill.
      do_fetch(32'h23, model_stalls(32'h23), "pre_rst");
      bus.pc        = 32'h300;
      bus.fetch_req = 1'b1;
      @(posedge clk); #1;
      check("rst_fill_state", 32'(dbg_state), 32'(FILL));
      reset         = 1'b1;
      bus.fetch_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      exp_hits   = 0;
      exp_misses = 0;
      @(negedge clk);
      check("mrst_stall", 32'(bus.stall), 32'd0);
      check("mrst_valid", 32'(bus.inst_valid), 32'd0);
      check("mrst_inst", bus.inst, 32'd0);
      check("mrst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk); #1;
      do_fetch(32'h23, LAT + 1, "post_rst");
      check_stats("post_rst");

      // MEM_LATENCY = 1 instance: two stall cycles, then the word.
      bus1.pc        = 32'h57;
      bus1.fetch_req = 1'b1;
      n = 0;
      @(negedge clk);
      check("lat1_ptr", bus1.mem_ptr, 32'h50);
      while (bus1.stall && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("lat1_stalls", 32'(n), 32'd2);
      check("lat1_valid", 32'(bus1.inst_valid), 32'd1);
      check("lat1_inst", bus1.inst, mem_word(32'h57));
      @(posedge clk); #1;
      bus1.fetch_req = 1'b0;

      check("q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
